// File: rtl/calc_entry_if.sv
// Keypad-to-calculator bus: key strobe, key code and entry mode in; operands, result and display value out.
// Latency: n/a (wiring only); all outputs are registered inside calc_entry.
// Backpressure: none; the engine accepts one key per sel pulse, every cycle.
// Ports: master (cursor/keypad side) drives sel, val, dec_mode; slave (calc_entry) drives the rest.
interface calc_entry_if #(
  parameter int W = 16
);
  logic         sel;
  logic [4:0]   val;
  logic         dec_mode;
  logic         restriction;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic [2:0]   opcode;
  logic [W-1:0] result;
  logic [W-1:0] disp;
  logic [1:0]   state;
  logic         err;

  modport master (
    output sel, val, dec_mode,
    input  restriction, op_a, op_b, opcode, result, disp, state, err
  );

  modport slave (
    input  sel, val, dec_mode,
    output restriction, op_a, op_b, opcode, result, disp, state, err
  );
endinterface

// File: rtl/calc_entry.sv
// Operand/operator entry engine: builds A and B from digit keys, latches the operator, computes on EXE.
// Latency: 1 cycle from a sel pulse (or dec_mode change) to every output, result included.
// Backpressure: none; each sel cycle is consumed immediately, sel=0 holds all state.
// Ports: clk, rst (async, active-high); bus = calc_entry_if.slave (sel/val/dec_mode in,
//   restriction/op_a/op_b/opcode/result/disp/state/err out).
// Build option: define CALC_OVF_FLAG_EN to get the overflow flag on err; otherwise err is tied low.
// The interface instance must use the same W as this module.
module calc_entry #(
  parameter int W          = 16,
  parameter int MAX_DIGITS = 4
) (
  input  logic          clk,
  input  logic          rst,
  calc_entry_if.slave   bus
);

  localparam int CW = $clog2(MAX_DIGITS + 1);

  typedef enum logic [1:0] {
    S_A   = 2'd0,
    S_B   = 2'd1,
    S_RES = 2'd2
  } state_t;

  localparam logic [4:0] K_ADD = 5'h10;
  localparam logic [4:0] K_MUL = 5'h11;
  localparam logic [4:0] K_AND = 5'h12;
  localparam logic [4:0] K_EXE = 5'h13;
  localparam logic [4:0] K_SUB = 5'h14;
  localparam logic [4:0] K_OR  = 5'h15;
  localparam logic [4:0] K_CE  = 5'h16;
  localparam logic [4:0] K_CLR = 5'h17;

  localparam logic [2:0] OPC_ADD = 3'd0;
  localparam logic [2:0] OPC_SUB = 3'd1;
  localparam logic [2:0] OPC_MUL = 3'd2;
  localparam logic [2:0] OPC_AND = 3'd3;
  localparam logic [2:0] OPC_OR  = 3'd4;

  state_t        st;
  logic [W-1:0]  op_a_q;
  logic [W-1:0]  op_b_q;
  logic [W-1:0]  result_q;
  logic [W-1:0]  disp_q;
  logic [2:0]    opcode_q;
  logic [CW-1:0] cnt;
  logic          restr_q;

  // ---------------- key decode ----------------
  logic         is_digit, is_op, is_exe, is_ce, is_clr;
  logic [3:0]   digit;
  logic [2:0]   key_opc;
  logic         digit_legal;
  logic         cnt_room;
  logic         mode_chg;
  logic         do_clr;

  always_comb begin
    is_digit = ~bus.val[4];
    digit    = bus.val[3:0];
    is_op    = 1'b0;
    key_opc  = OPC_ADD;
    case (bus.val)
      K_ADD:   begin is_op = 1'b1; key_opc = OPC_ADD; end
      K_SUB:   begin is_op = 1'b1; key_opc = OPC_SUB; end
      K_MUL:   begin is_op = 1'b1; key_opc = OPC_MUL; end
      K_AND:   begin is_op = 1'b1; key_opc = OPC_AND; end
      K_OR:    begin is_op = 1'b1; key_opc = OPC_OR;  end
      default: begin is_op = 1'b0; key_opc = OPC_ADD; end
    endcase
    is_exe = (bus.val == K_EXE);
    is_ce  = (bus.val == K_CE);
    is_clr = (bus.val == K_CLR);
  end

  // Decimal mode rejects A..F outright; the digit-count limit is applied separately
  // because a digit in S_RES starts a fresh operand regardless of cnt.
  assign digit_legal = is_digit && (!restr_q || (digit <= 4'd9));
  assign cnt_room    = (cnt != CW'(MAX_DIGITS));

  // restr_q doubles as the previous dec_mode sample, so a mismatch is the mode edge.
  assign mode_chg = (bus.dec_mode != restr_q);

  // CE in S_RES is a full clear; a mode edge wins over any key in the same cycle.
  assign do_clr = mode_chg ||
                  (bus.sel && (is_clr || (is_ce && (st == S_RES))));

  // ---------------- digit accumulation ----------------
  logic [W-1:0] acc_src;
  logic [W-1:0] acc_scaled;
  logic [W-1:0] acc_next;
  logic [W-1:0] digit_ext;

  assign digit_ext  = W'(digit);
  assign acc_src    = (st == S_B) ? op_b_q : op_a_q;
  // x*10 = x*8 + x*2; x*16 is a plain shift. Both truncate to W bits.
  assign acc_scaled = restr_q ? ((acc_src << 3) + (acc_src << 1)) : (acc_src << 4);
  assign acc_next   = acc_scaled + digit_ext;

  // ---------------- ALU ----------------
  // In S_RES a repeated EXE operates on the previous result instead of A.
  logic [W-1:0] alu_x;
  logic [W-1:0] alu_y;
  logic [W-1:0] add_lo;
  logic [W-1:0] mul_lo;
  logic [W-1:0] alu_out;

  assign alu_x = (st == S_RES) ? result_q : op_a_q;
  assign alu_y = op_b_q;

`ifdef CALC_OVF_FLAG_EN
  logic [W:0]     sum_full;
  logic [2*W-1:0] prod_full;
  logic           alu_ovf;
  logic           err_q;

  assign sum_full  = {1'b0, alu_x} + {1'b0, alu_y};
  assign prod_full = {{W{1'b0}}, alu_x} * {{W{1'b0}}, alu_y};
  assign add_lo    = sum_full[W-1:0];
  assign mul_lo    = prod_full[W-1:0];

  always_comb begin
    alu_ovf = 1'b0;
    case (opcode_q)
      OPC_ADD: alu_ovf = sum_full[W];
      OPC_SUB: alu_ovf = (alu_x < alu_y);
      OPC_MUL: alu_ovf = |prod_full[2*W-1:W];
      default: alu_ovf = 1'b0;
    endcase
  end

  // err follows the same key events as the main FSM; kept separate so the
  // disabled build carries no trace of it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (do_clr) begin
      err_q <= 1'b0;
    end else if (bus.sel) begin
      if (is_exe && (st != S_A))
        err_q <= alu_ovf;
      else if ((st == S_RES) && digit_legal)
        err_q <= 1'b0;
    end
  end

  assign bus.err = err_q;
`else
  assign add_lo  = alu_x + alu_y;
  assign mul_lo  = alu_x * alu_y;
  assign bus.err = 1'b0;
`endif

  always_comb begin
    alu_out = '0;
    case (opcode_q)
      OPC_ADD: alu_out = add_lo;
      OPC_SUB: alu_out = alu_x - alu_y;
      OPC_MUL: alu_out = mul_lo;
      OPC_AND: alu_out = alu_x & alu_y;
      OPC_OR:  alu_out = alu_x | alu_y;
      default: alu_out = '0;
    endcase
  end

  // ---------------- entry FSM ----------------
  // disp is registered alongside the value it mirrors, so each branch sets it
  // to what the display should show in the new state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st       <= S_A;
      op_a_q   <= '0;
      op_b_q   <= '0;
      result_q <= '0;
      disp_q   <= '0;
      opcode_q <= OPC_ADD;
      cnt      <= '0;
      restr_q  <= 1'b0;
    end else begin
      restr_q <= bus.dec_mode;
      if (do_clr) begin
        st       <= S_A;
        op_a_q   <= '0;
        op_b_q   <= '0;
        result_q <= '0;
        disp_q   <= '0;
        opcode_q <= OPC_ADD;
        cnt      <= '0;
      end else if (bus.sel) begin
        case (st)
          S_A: begin
            if (digit_legal && cnt_room) begin
              op_a_q <= acc_next;
              disp_q <= acc_next;
              cnt    <= cnt + CW'(1);
            end else if (is_op) begin
              opcode_q <= key_opc;
              op_b_q   <= '0;
              cnt      <= '0;
              disp_q   <= op_a_q;
              st       <= S_B;
            end else if (is_ce) begin
              op_a_q <= '0;
              cnt    <= '0;
              disp_q <= '0;
            end
          end
          S_B: begin
            if (digit_legal && cnt_room) begin
              op_b_q <= acc_next;
              disp_q <= acc_next;
              cnt    <= cnt + CW'(1);
            end else if (is_op) begin
              // Operator may only be corrected before any B digit is typed.
              if (cnt == '0)
                opcode_q <= key_opc;
            end else if (is_exe) begin
              result_q <= alu_out;
              disp_q   <= alu_out;
              st       <= S_RES;
            end else if (is_ce) begin
              op_b_q <= '0;
              cnt    <= '0;
              disp_q <= op_a_q;
            end
          end
          S_RES: begin
            if (digit_legal) begin
              op_a_q <= digit_ext;
              disp_q <= digit_ext;
              cnt    <= CW'(1);
              st     <= S_A;
            end else if (is_op) begin
              op_a_q   <= result_q;
              opcode_q <= key_opc;
              op_b_q   <= '0;
              cnt      <= '0;
              disp_q   <= result_q;
              st       <= S_B;
            end else if (is_exe) begin
              op_a_q   <= result_q;
              result_q <= alu_out;
              disp_q   <= alu_out;
            end
          end
          default: st <= S_A;
        endcase
      end
    end
  end

  assign bus.restriction = restr_q;
  assign bus.op_a        = op_a_q;
  assign bus.op_b        = op_b_q;
  assign bus.opcode      = opcode_q;
  assign bus.result      = result_q;
  assign bus.disp        = disp_q;
  assign bus.state       = st;

endmodule

// File: tb/tb_calc_entry.sv
// Directed bench for calc_entry: each task drives key sequences and checks hand-computed values.
// Latency: keys are driven on the falling edge and outputs sampled on the following falling edge.
// Backpressure: none exercised; the engine takes one key per sel pulse.
module tb_calc_entry;

`ifdef CALC_OVF_FLAG_EN
  localparam logic OVF = 1'b1;
`else
  localparam logic OVF = 1'b0;
`endif

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  calc_entry_if #(.W(16)) bus ();

  calc_entry #(.W(16), .MAX_DIGITS(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout reached");
    $fatal(1);
  end

  task automatic press(input logic [4:0] k);
    @(negedge clk);
    bus.sel = 1'b1;
    bus.val = k;
    @(negedge clk);
    bus.sel = 1'b0;
    bus.val = 5'h1F;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.sel = 1'b0;
    bus.val = 5'h1F;
    bus.dec_mode = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (bus.op_a !== 16'h0) begin errors++; $display("FAIL rst_op_a got %h want 0000", bus.op_a); end
    checks++; if (bus.op_b !== 16'h0) begin errors++; $display("FAIL rst_op_b got %h want 0000", bus.op_b); end
    checks++; if (bus.result !== 16'h0) begin errors++; $display("FAIL rst_result got %h want 0000", bus.result); end
    checks++; if (bus.disp !== 16'h0) begin errors++; $display("FAIL rst_disp got %h want 0000", bus.disp); end
    checks++; if (bus.opcode !== 3'd0) begin errors++; $display("FAIL rst_opcode got %0d want 0", bus.opcode); end
    checks++; if (bus.state !== 2'd0) begin errors++; $display("FAIL rst_state got %0d want 0", bus.state); end
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL rst_err got %b want 0", bus.err); end
    checks++; if (bus.restriction !== 1'b0) begin errors++; $display("FAIL rst_restriction got %b want 0", bus.restriction); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_hex;
    press(5'h17);
    press(5'h01); press(5'h02); press(5'h10);
    checks++; if (bus.state !== 2'd1) begin errors++; $display("FAIL hex_state_b got %0d want 1", bus.state); end
    checks++; if (bus.disp !== 16'h0012) begin errors++; $display("FAIL hex_disp_a got %h want 0012", bus.disp); end
    press(5'h03);
    checks++; if (bus.disp !== 16'h0003) begin errors++; $display("FAIL hex_disp_b got %h want 0003", bus.disp); end
    press(5'h13);
    checks++; if (bus.op_a !== 16'h0012) begin errors++; $display("FAIL hex_op_a got %h want 0012", bus.op_a); end
    checks++; if (bus.op_b !== 16'h0003) begin errors++; $display("FAIL hex_op_b got %h want 0003", bus.op_b); end
    checks++; if (bus.result !== 16'h0015) begin errors++; $display("FAIL hex_result got %h want 0015", bus.result); end
    checks++; if (bus.state !== 2'd2) begin errors++; $display("FAIL hex_state_res got %0d want 2", bus.state); end
    checks++; if (bus.disp !== 16'h0015) begin errors++; $display("FAIL hex_disp_res got %h want 0015", bus.disp); end
  endtask

  task automatic test_decimal;
    @(negedge clk);
    bus.dec_mode = 1'b1;
    @(negedge clk);
    checks++; if (bus.restriction !== 1'b1) begin errors++; $display("FAIL dec_restriction got %b want 1", bus.restriction); end
    checks++; if (bus.result !== 16'h0) begin errors++; $display("FAIL dec_mode_clear got %h want 0000", bus.result); end
    press(5'h01); press(5'h0A);
    checks++; if (bus.op_a !== 16'h0001) begin errors++; $display("FAIL dec_ignore_A got %h want 0001", bus.op_a); end
    press(5'h02);
    checks++; if (bus.op_a !== 16'h000C) begin errors++; $display("FAIL dec_op_a got %h want 000c", bus.op_a); end
    press(5'h11); press(5'h03); press(5'h13);
    checks++; if (bus.result !== 16'h0024) begin errors++; $display("FAIL dec_result got %h want 0024", bus.result); end
    @(negedge clk);
    bus.dec_mode = 1'b0;
    @(negedge clk);
    checks++; if (bus.restriction !== 1'b0) begin errors++; $display("FAIL dec_back_restriction got %b want 0", bus.restriction); end
    checks++; if (bus.result !== 16'h0 || bus.state !== 2'd0) begin errors++; $display("FAIL dec_back_clear got result %h state %0d want 0000 0", bus.result, bus.state); end
  endtask

  task automatic test_digit_limit_ce;
    press(5'h17);
    press(5'h01); press(5'h02); press(5'h03); press(5'h04); press(5'h05);
    checks++; if (bus.op_a !== 16'h1234) begin errors++; $display("FAIL limit_op_a got %h want 1234", bus.op_a); end
    press(5'h10); press(5'h07);
    checks++; if (bus.disp !== 16'h0007) begin errors++; $display("FAIL ce_disp_b got %h want 0007", bus.disp); end
    press(5'h16);
    checks++; if (bus.op_b !== 16'h0 || bus.disp !== 16'h1234) begin errors++; $display("FAIL ce_clear_b got op_b %h disp %h want 0000 1234", bus.op_b, bus.disp); end
    press(5'h09); press(5'h13);
    checks++; if (bus.result !== 16'h123D) begin errors++; $display("FAIL ce_result got %h want 123d", bus.result); end
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL ce_err got %b want 0", bus.err); end
  endtask

  task automatic test_wrap_flag;
    press(5'h17);
    press(5'h00); press(5'h14); press(5'h01); press(5'h13);
    checks++; if (bus.result !== 16'hFFFF) begin errors++; $display("FAIL wrap_result got %h want ffff", bus.result); end
    checks++; if (bus.err !== OVF) begin errors++; $display("FAIL wrap_err got %b want %b", bus.err, OVF); end
    press(5'h13);
    checks++; if (bus.result !== 16'hFFFE) begin errors++; $display("FAIL repeat_result got %h want fffe", bus.result); end
    checks++; if (bus.op_a !== 16'hFFFF) begin errors++; $display("FAIL repeat_op_a got %h want ffff", bus.op_a); end
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL repeat_err got %b want 0", bus.err); end
    press(5'h16);
    checks++; if (bus.state !== 2'd0 || bus.result !== 16'h0 || bus.op_b !== 16'h0) begin errors++; $display("FAIL ce_res_clear got state %0d result %h op_b %h want 0 0000 0000", bus.state, bus.result, bus.op_b); end
  endtask

  task automatic test_chain;
    press(5'h17);
    press(5'h05); press(5'h10); press(5'h05); press(5'h13);
    checks++; if (bus.result !== 16'h000A) begin errors++; $display("FAIL chain_first got %h want 000a", bus.result); end
    press(5'h10);
    checks++; if (bus.state !== 2'd1 || bus.op_a !== 16'h000A || bus.disp !== 16'h000A) begin errors++; $display("FAIL chain_op got state %0d op_a %h disp %h want 1 000a 000a", bus.state, bus.op_a, bus.disp); end
    press(5'h01); press(5'h13);
    checks++; if (bus.result !== 16'h000B) begin errors++; $display("FAIL chain_result got %h want 000b", bus.result); end
    press(5'h03);
    checks++; if (bus.state !== 2'd0 || bus.op_a !== 16'h0003 || bus.disp !== 16'h0003) begin errors++; $display("FAIL res_digit got state %0d op_a %h disp %h want 0 0003 0003", bus.state, bus.op_a, bus.disp); end
    press(5'h17);
    press(5'h0F); press(5'h0F); press(5'h0F); press(5'h0F); press(5'h11); press(5'h02); press(5'h13);
    checks++; if (bus.result !== 16'hFFFE) begin errors++; $display("FAIL mul_low got %h want fffe", bus.result); end
    checks++; if (bus.err !== OVF) begin errors++; $display("FAIL mul_err got %b want %b", bus.err, OVF); end
    press(5'h01);
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL digit_clears_err got %b want 0", bus.err); end
  endtask

  task automatic test_ops;
    press(5'h17);
    press(5'h09); press(5'h12); press(5'h15);
    checks++; if (bus.opcode !== 3'd4) begin errors++; $display("FAIL op_replace got %0d want 4", bus.opcode); end
    press(5'h06); press(5'h13);
    checks++; if (bus.result !== 16'h000F) begin errors++; $display("FAIL or_result got %h want 000f", bus.result); end
    press(5'h12); press(5'h0C); press(5'h13);
    checks++; if (bus.result !== 16'h000C) begin errors++; $display("FAIL and_result got %h want 000c", bus.result); end
    press(5'h17);
    press(5'h08); press(5'h14); press(5'h03); press(5'h10);
    checks++; if (bus.opcode !== 3'd1) begin errors++; $display("FAIL op_locked got %0d want 1", bus.opcode); end
    press(5'h13);
    checks++; if (bus.result !== 16'h0005) begin errors++; $display("FAIL sub_result got %h want 0005", bus.result); end
    press(5'h17);
    press(5'h02); press(5'h13); press(5'h18);
    checks++; if (bus.state !== 2'd0 || bus.op_a !== 16'h0002) begin errors++; $display("FAIL exe_in_a got state %0d op_a %h want 0 0002", bus.state, bus.op_a); end
    @(negedge clk);
    bus.val = 5'h07;
    repeat (3) @(negedge clk);
    checks++; if (bus.op_a !== 16'h0002) begin errors++; $display("FAIL sel_low_hold got %h want 0002", bus.op_a); end
    bus.val = 5'h1F;
  endtask

  task automatic test_mode_toggle_sb;
    press(5'h17);
    press(5'h04); press(5'h10); press(5'h02);
    checks++; if (bus.state !== 2'd1 || bus.op_b !== 16'h0002) begin errors++; $display("FAIL toggle_setup got state %0d op_b %h want 1 0002", bus.state, bus.op_b); end
    @(negedge clk);
    bus.dec_mode = 1'b1;
    bus.sel = 1'b1;
    bus.val = 5'h03;
    @(negedge clk);
    bus.sel = 1'b0;
    bus.val = 5'h1F;
    checks++; if (bus.state !== 2'd0 || bus.op_a !== 16'h0 || bus.op_b !== 16'h0 || bus.disp !== 16'h0 || bus.opcode !== 3'd0) begin errors++; $display("FAIL toggle_clear got state %0d op_a %h op_b %h disp %h opcode %0d want all 0", bus.state, bus.op_a, bus.op_b, bus.disp, bus.opcode); end
    checks++; if (bus.restriction !== 1'b1) begin errors++; $display("FAIL toggle_restriction got %b want 1", bus.restriction); end
    bus.dec_mode = 1'b0;
    @(negedge clk);
    checks++; if (bus.restriction !== 1'b0) begin errors++; $display("FAIL toggle_back got %b want 0", bus.restriction); end
  endtask

  task automatic test_async_reset;
    press(5'h17);
    press(5'h04); press(5'h15); press(5'h02);
    checks++; if (bus.opcode !== 3'd4 || bus.disp !== 16'h0002) begin errors++; $display("FAIL areset_setup got opcode %0d disp %h want 4 0002", bus.opcode, bus.disp); end
    #2 rst = 1'b1;
    #1;
    checks++; if (bus.op_a !== 16'h0 || bus.op_b !== 16'h0 || bus.disp !== 16'h0 || bus.opcode !== 3'd0 || bus.state !== 2'd0) begin errors++; $display("FAIL areset_now got op_a %h op_b %h disp %h opcode %0d state %0d want all 0", bus.op_a, bus.op_b, bus.disp, bus.opcode, bus.state); end
    @(negedge clk);
    rst = 1'b0;
    press(5'h05);
    checks++; if (bus.op_a !== 16'h0005 || bus.state !== 2'd0) begin errors++; $display("FAIL areset_after got op_a %h state %0d want 0005 0", bus.op_a, bus.state); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_hex();
    test_decimal();
    test_digit_limit_ce();
    test_wrap_flag();
    test_chain();
    test_ops();
    test_mode_toggle_sb();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/calc_entry.md
# calc_entry

Operand/operator entry engine for the on-screen keypad calculator. It sits directly downstream of the grid cursor and consumes the cursor's 5-bit key code `val` and its one-cycle select pulse. It accumulates digit keys into operands A and B, latches the operator, and computes the result on EXE. It drives the value shown on the VGA display and the `restriction` (decimal-mode) line back to the cursor.

## Interface
- `W`, 16 — operand/result width in bits
- `MAX_DIGITS`, 4 — maximum digits accepted per operand
- `clk` in 1 — system clock
- `rst` in 1 — reset, asynchronous, active-high
- `sel` in 1 — key-select pulse from the cursor (one cycle per press)
- `val` in 5 — key code: 0x00–0x0F digit; 0x10 add; 0x11 mul; 0x12 and; 0x13 EXE; 0x14 sub; 0x15 or; 0x16 CE; 0x17 CLR; other codes ignored
- `dec_mode` in 1 — 1 = decimal entry, 0 = hexadecimal entry
- `restriction` out 1 — registered copy of `dec_mode`, fed to the cursor
- `op_a` out W — operand A
- `op_b` out W — operand B
- `opcode` out 3 — 0 add, 1 sub, 2 mul, 3 and, 4 or
- `result` out W — last computed result
- `disp` out W — value to display
- `state` out 2 — 0 S_A, 1 S_B, 2 S_RES
- `err` out 1 — overflow flag (see Configuration)

## Operation
- Keys are acted on only in cycles where `sel`=1. With `sel`=0 all registers hold.
- Digit accumulation: reg = reg*base + d, where base = 10 if `restriction`=1, else 16.
  - In decimal mode, digits > 9 are ignored.
  - A digit is ignored once `cnt` == MAX_DIGITS.
  - Arithmetic is truncated to W bits.
- S_A (entering A):
  - digit → accumulate into `op_a`, `cnt`++
  - operator → latch `opcode`; `op_b`=0, `cnt`=0; go to S_B
  - EXE → ignored
  - CE → `op_a`=0, `cnt`=0
- S_B (entering B):
  - digit → accumulate into `op_b`
  - operator → replaces `opcode` only if `cnt`=0, else ignored
  - EXE → `result` = A op B; `err` updated; go to S_RES
  - CE → `op_b`=0, `cnt`=0
- S_RES (showing result):
  - digit → `op_a`=d, `cnt`=1, `err`=0; go to S_A
  - operator → `op_a`=`result`, latch `opcode`, `op_b`=0, `cnt`=0; go to S_B (chaining)
  - EXE → `op_a`=`result`, then recompute with the same `op_b` and `opcode` (repeat)
  - CE → behaves as CLR
- CLR in any state: all operands, `result`, `cnt` and `err` cleared; `opcode`=0; go to S_A.
- Arithmetic, modulo 2^W:
  - add wraps
  - sub wraps (0−1 = all ones)
  - mul keeps the low W bits
  - and/or are bitwise
- `disp`:
  - S_A → `op_a`
  - S_B → `op_b` if `cnt`>0, else `op_a`
  - S_RES → `result`
- Mode change: any change of `dec_mode` (registered edge detect) performs CLR in the same cycle that `restriction` updates. This mirrors the cursor's return to (0,0) on its restriction edge.

## Timing
- Reset values of all outputs: `op_a`, `op_b`, `result`, `disp` = 0; `opcode`=0; `state`=S_A; `err`=0; `restriction`=0.
- All outputs are registered. The effect of a `sel` cycle is visible on the next rising edge (latency 1), including `result` after EXE. No multi-cycle operations.
- `restriction` lags `dec_mode` by one cycle.
- Simultaneous `sel` and a `dec_mode` change: the mode-change CLR wins; the key is dropped.
- `rst` asserted mid-entry: immediate asynchronous return to reset values; no pending state survives.

## Configuration
- `CALC_OVF_FLAG_EN` defined: `err` is set on EXE when any of these occur:
  - add carry-out
  - sub borrow (A < B)
  - mul high W bits nonzero
  - `err` is cleared by CLR, CE-in-S_RES, or a new digit in S_RES.
- `CALC_OVF_FLAG_EN` undefined: `err` is tied to 0 and no overflow logic is synthesized.

## Test plan
- Hex mode: keys 1, 2, add, 3, EXE → `op_a`=0x0012, `op_b`=0x0003, `result`=0x0015, `state`=2, `disp`=0x0015.
- Decimal mode (`dec_mode`=1 held): keys 1, 2, mul, 3, EXE → `result`=0x0024 (36). Key 0x0A while in decimal mode is ignored.
- Digit limit and CE: keys 1, 2, 3, 4, 5 → `op_a`=0x1234. Then add, 7, CE, 9, EXE → `result`=0x123D.
- Wrap and flag: keys 0, sub, 1, EXE → `result`=0xFFFF; `err`=1 with the macro defined, 0 without. Then EXE again → `result`=0xFFFE.
- Chaining and boundary: 5, add, 5, EXE, add, 1, EXE → `result`=0x000B. Toggling `dec_mode` in S_B → all outputs zero and `state`=0 one cycle later, with `restriction` following.
- Async reset during S_B after keys 4, or, 2 → all outputs zero before the next clock edge.
